button_event_ctrl: RTL and testbench
====================================

// Module: button_event_ctrl
// PURPOSE
//  Sequences debounced button levels into a single stream of press events with typematic auto-repeat.
//  Sits after the button debouncer and feeds the on-board menu/OSD logic.
//  Round-robin arbitration shares the one event port fairly among all buttons.
// PARAMETERS
//  NUM_BUTTONS    4              number of button inputs (2..16)
//  ID_BITS        2              width of event_id; must satisfy 2**ID_BITS >= NUM_BUTTONS
//  TICK_DIV_BITS  15             tick divider width; 1 tick = 2**TICK_DIV_BITS clk (1.31 ms @ 25 MHz)
//  DELAY_TICKS    8'd200         ticks from press to first repeat (>=1)
//  REPEAT_TICKS   8'd50          ticks between subsequent repeats (>=1)
//  REPEAT_MASK    {NUM_BUTTONS{1'b1}}  bit d=1 enables auto-repeat on button d
// PORTS
//  clk           in   1            system clock
//  rst_in        in   1            asynchronous, active-low reset
//  enable        in   1            1 = generate events; 0 = flush and hold idle
//  button_in     in   NUM_BUTTONS  debounced levels, active-high, synchronous to clk
//  event_valid   out  1            event present on event_id/event_repeat
//  event_ready   in   1            consumer accepts event when valid & ready at posedge
//  event_id      out  ID_BITS      index of button that generated the event
//  event_repeat  out  1            0 = initial press, 1 = auto-repeat
//  overrun       out  1            sticky: an event was coalesced/dropped; cleared only by reset
// BEHAVIOUR
//  Reset (rst_in low, async): event_valid=0, event_id=0, event_repeat=0, overrun=0, all pending=0,
//   all FSMs IDLE, tick divider=0, btn_prev=0, last_grant=NUM_BUTTONS-1 (button 0 first).
//  Tick: free-running divider; tick is 1-cycle pulse when divider is all ones.
//  Edge detect: btn_prev <= button_in each cycle; press[d] = button_in[d] & ~btn_prev[d].
//  Per-button FSM, 8-bit counter cnt[d]:
//   IDLE  : press -> pending[d]=1, rpt[d]=0; if REPEAT_MASK[d] -> DELAY, cnt=DELAY_TICKS.
//   DELAY : button low -> IDLE. tick & cnt==1 -> repeat event, cnt=REPEAT_TICKS, -> REPEAT.
//           tick & cnt>1 -> cnt-1.
//   REPEAT: button low -> IDLE. tick & cnt==1 -> repeat event, cnt=REPEAT_TICKS. tick -> cnt-1.
//   Release takes priority over a same-cycle expiry (no repeat issued).
//  Repeat event: if pending[d]==0 -> pending[d]=1, rpt[d]=1; else coalesced, overrun=1.
//  Press while pending[d] already 1 (not possible without release+repress): coalesced, overrun=1,
//   rpt[d]=0 (press marks the event as non-repeat).
//  Arbiter: round-robin over pending; search starts at last_grant+1, wraps at NUM_BUTTONS-1 -> 0.
//  Output register loads when any pending & (~event_valid | event_ready): event_id=winner,
//   event_repeat=rpt[winner], event_valid=1, pending[winner] cleared, last_grant=winner.
//  Same-cycle grant and new set on same button: set wins, pending stays 1 (second event kept).
//  event_valid & ~event_ready: id/repeat held stable; no new grant; pending bits keep collecting.
//  Throughput 1 event/cycle when event_ready held high.
//  Latency: press sampled at edge k -> pending at k; event_valid=1 after edge k+1 if port free.
//  enable=0: FSMs forced IDLE, pending/rpt cleared, no new grants; an in-flight event stays
//   valid until accepted. btn_prev still tracks button_in (button held across enable rise = no event).
//  Button IDs >= NUM_BUTTONS never produced.
// TESTING (TICK_DIV_BITS=2, DELAY_TICKS=3, REPEAT_TICKS=2, event_ready=1 unless stated)
//  1 Reset mid-event: rst_in low while event_valid=1 -> event_valid=0 immediately, overrun=0.
//  2 Single press btn1 held 30 cycles -> event (id=1,rep=0) 2 cycles after press, then
//    (id=1,rep=1) after 3 ticks (12 clk), then every 2 ticks (8 clk); release -> no further events.
//  3 Press btns 0,2,3 in same cycle -> events id 0,2,3 on consecutive cycles; next simultaneous
//    press of 0,2 after last_grant=3 -> order 0,2; after last_grant=0 -> order 2,0.
//  4 event_ready=0 for 40 cycles with btn0 held -> first event held stable; repeat coalesced,
//    overrun=1 and stays 1; on ready=1 exactly one pending rep=1 event follows.
//  5 REPEAT_MASK=4'b1110, hold btn0 40 cycles -> exactly one event (id=0,rep=0).
//  6 enable=0 while btn2 held in REPEAT with pending set -> no new events; in-flight event still
//    accepted; enable=1 with btn2 still held -> no event until release and re-press.

Source files
------------

// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into one stream of press / auto-repeat events.
// Each button has a typematic delay/repeat FSM; a round-robin arbiter shares the single event port.
module button_event_ctrl #(
    parameter int                     NUM_BUTTONS   = 4,
    parameter int                     ID_BITS       = 2,
    parameter int                     TICK_DIV_BITS = 15,
    parameter logic [7:0]             DELAY_TICKS   = 8'd200,
    parameter logic [7:0]             REPEAT_TICKS  = 8'd50,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK   = {NUM_BUTTONS{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rst_in,
    input  logic                   enable,
    input  logic [NUM_BUTTONS-1:0] button_in,
    output logic                   event_valid,
    input  logic                   event_ready,
    output logic [ID_BITS-1:0]     event_id,
    output logic                   event_repeat,
    output logic                   overrun
);

    localparam int IDXW = $clog2(NUM_BUTTONS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } btn_state_t;

    logic [TICK_DIV_BITS-1:0] tick_div;
    logic                     tick;
    logic [NUM_BUTTONS-1:0]   btn_prev;
    logic [NUM_BUTTONS-1:0]   press;

    btn_state_t               state_q [NUM_BUTTONS];
    btn_state_t               state_d [NUM_BUTTONS];
    logic [7:0]               cnt_q   [NUM_BUTTONS];
    logic [7:0]               cnt_d   [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0]   rpt_evt;

    logic [NUM_BUTTONS-1:0]   pending_q, pending_d;
    logic [NUM_BUTTONS-1:0]   rpt_q, rpt_d;
    logic [NUM_BUTTONS-1:0]   coalesce;
    logic [NUM_BUTTONS-1:0]   grant_vec;

    logic [IDXW-1:0]          last_grant;
    logic [IDXW-1:0]          winner;
    logic [IDXW-1:0]          cand;
    logic                     found;
    logic                     grant_fire;

    assign tick  = &tick_div;
    assign press = button_in & ~btn_prev;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            tick_div <= '0;
            btn_prev <= '0;
        end else begin
            tick_div <= tick_div + TICK_DIV_BITS'(1);
            btn_prev <= button_in;
        end
    end

    // NOTE: the per-button state array is small control state, so it is reset like any other flop.
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int d = 0; d < NUM_BUTTONS; d++) begin
                state_q[d] <= ST_IDLE;
                cnt_q[d]   <= '0;
            end
        end else begin
            for (int d = 0; d < NUM_BUTTONS; d++) begin
                state_q[d] <= state_d[d];
                cnt_q[d]   <= cnt_d[d];
            end
        end
    end

    // Release is tested before expiry so a same-cycle release suppresses the repeat.
    always_comb begin
        for (int d = 0; d < NUM_BUTTONS; d++) begin
            // NOTE: defaults first keep every path assigned, so no latches are inferred.
            state_d[d] = state_q[d];
            cnt_d[d]   = cnt_q[d];
            rpt_evt[d] = 1'b0;
            if (!enable) begin
                state_d[d] = ST_IDLE;
            end else begin
                case (state_q[d])
                    ST_IDLE: begin
                        if (press[d] && REPEAT_MASK[d]) begin
                            state_d[d] = ST_DELAY;
                            cnt_d[d]   = DELAY_TICKS;
                        end
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (!button_in[d]) begin
                            state_d[d] = ST_IDLE;
                        end else if (tick) begin
                            if (cnt_q[d] == 8'd1) begin
                                rpt_evt[d] = 1'b1;
                                cnt_d[d]   = REPEAT_TICKS;
                                state_d[d] = ST_REPEAT;
                            end else begin
                                cnt_d[d] = cnt_q[d] - 8'd1;
                            end
                        end
                    end
                    default: state_d[d] = ST_IDLE;
                endcase
            end
        end
    end

    // Round-robin search starting just after the last granted button.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 1; i <= NUM_BUTTONS; i++) begin
            cand = IDXW'((int'(last_grant) + i) % NUM_BUTTONS);
            if (!found && pending_q[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign grant_fire = enable & found & (~event_valid | event_ready);

    always_comb begin
        grant_vec = '0;
        if (grant_fire) begin
            grant_vec[winner] = 1'b1;
        end
    end

    // A new event on a button being granted this cycle is kept rather than coalesced.
    always_comb begin
        pending_d = pending_q;
        rpt_d     = rpt_q;
        coalesce  = '0;
        if (!enable) begin
            pending_d = '0;
            rpt_d     = '0;
        end else begin
            for (int d = 0; d < NUM_BUTTONS; d++) begin
                if (press[d] || rpt_evt[d]) begin
                    if (pending_q[d] && !grant_vec[d]) begin
                        coalesce[d] = 1'b1;
                        if (press[d]) begin
                            rpt_d[d] = 1'b0;
                        end
                    end else begin
                        pending_d[d] = 1'b1;
                        rpt_d[d]     = rpt_evt[d];
                    end
                end else if (grant_vec[d]) begin
                    pending_d[d] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            pending_q    <= '0;
            rpt_q        <= '0;
            last_grant   <= IDXW'(NUM_BUTTONS - 1);
            event_valid  <= 1'b0;
            event_id     <= '0;
            event_repeat <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            pending_q <= pending_d;
            rpt_q     <= rpt_d;
            if (|coalesce) begin
                overrun <= 1'b1;
            end
            if (grant_fire) begin
                event_valid  <= 1'b1;
                event_id     <= ID_BITS'(winner);
                event_repeat <= rpt_q[winner];
                last_grant   <= winner;
            end else if (event_ready) begin
                event_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Randomised and directed bench for button_event_ctrl against a tick-counting reference model.
// A second instance with auto-repeat disabled on button 0 covers the repeat mask.
module tb_button_event_ctrl;

    localparam int NB   = 4;
    localparam int DLY  = 3;
    localparam int RPT  = 2;
    localparam int TDIV = 4;
    localparam logic [NB-1:0] MASK = 4'b1111;

    logic          clk = 1'b0;
    logic          rst_in = 1'b0;
    logic          enable = 1'b0;
    logic [NB-1:0] button_in = '0;
    logic          event_ready = 1'b0;
    logic          event_valid, event_repeat, overrun;
    logic [1:0]    event_id;
    logic          ev2_valid, ev2_repeat, ev2_overrun;
    logic [1:0]    ev2_id;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    button_event_ctrl #(
        .NUM_BUTTONS(NB), .ID_BITS(2), .TICK_DIV_BITS(2),
        .DELAY_TICKS(8'd3), .REPEAT_TICKS(8'd2), .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk), .rst_in(rst_in), .enable(enable), .button_in(button_in),
        .event_valid(event_valid), .event_ready(event_ready), .event_id(event_id),
        .event_repeat(event_repeat), .overrun(overrun)
    );

    button_event_ctrl #(
        .NUM_BUTTONS(NB), .ID_BITS(2), .TICK_DIV_BITS(2),
        .DELAY_TICKS(8'd3), .REPEAT_TICKS(8'd2), .REPEAT_MASK(4'b1110)
    ) dut_nomask0 (
        .clk(clk), .rst_in(rst_in), .enable(enable), .button_in(button_in),
        .event_valid(ev2_valid), .event_ready(event_ready), .event_id(ev2_id),
        .event_repeat(ev2_repeat), .overrun(ev2_overrun)
    );

    // Reference model state: per-button hold time in ticks, pending/repeat flags, output slot.
    int m_n, m_id, m_last;
    bit m_valid, m_rep, m_ovr;
    bit m_pend [NB];
    bit m_rpt  [NB];
    bit m_armed[NB];
    bit m_prev [NB];
    int m_held [NB];

    bit ev2_count_on = 1'b0;
    int ev2_count, ev2_last_id, ev2_last_rep;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_n = 0; m_id = 0; m_last = NB - 1;
        m_valid = 0; m_rep = 0; m_ovr = 0;
        for (int d = 0; d < NB; d++) begin
            m_pend[d] = 0; m_rpt[d] = 0; m_armed[d] = 0; m_prev[d] = 0; m_held[d] = 0;
        end
    endfunction

    // Advances the model across one rising edge with the inputs presented before it.
    function automatic void model_step(input bit en, input logic [NB-1:0] btn, input bit rdy);
        bit tick, press, set, srep;
        int win;
        tick = (m_n % TDIV) == TDIV - 1;
        m_n++;
        win = -1;
        if (en && (!m_valid || rdy)) begin
            for (int i = 1; i <= NB; i++) begin
                int c;
                c = (m_last + i) % NB;
                if (win < 0 && m_pend[c]) win = c;
            end
        end
        if (win >= 0) begin
            m_valid = 1; m_id = win; m_rep = m_rpt[win]; m_last = win; m_pend[win] = 0;
        end else if (rdy) begin
            m_valid = 0;
        end
        for (int d = 0; d < NB; d++) begin
            press = btn[d] && !m_prev[d];
            set = 0; srep = 0;
            if (!en) begin
                m_armed[d] = 0; m_pend[d] = 0; m_rpt[d] = 0;
            end else begin
                if (press) begin
                    set = 1;
                    if (MASK[d]) begin m_armed[d] = 1; m_held[d] = 0; end
                end else if (m_armed[d]) begin
                    if (!btn[d]) m_armed[d] = 0;
                    else if (tick) begin
                        m_held[d]++;
                        if (m_held[d] == DLY || (m_held[d] > DLY && (m_held[d] - DLY) % RPT == 0)) begin
                            set = 1; srep = 1;
                        end
                    end
                end
                if (set) begin
                    if (m_pend[d]) begin
                        m_ovr = 1;
                        if (!srep) m_rpt[d] = 0;
                    end else begin
                        m_pend[d] = 1; m_rpt[d] = srep;
                    end
                end
            end
            m_prev[d] = btn[d];
        end
    endfunction

    task automatic cycle(input bit en, input logic [NB-1:0] btn, input bit rdy);
        enable = en; button_in = btn; event_ready = rdy;
        model_step(en, btn, rdy);
        @(posedge clk);
        @(negedge clk);
        check("valid", 32'(event_valid), 32'(m_valid));
        if (m_valid) begin
            check("id", 32'(event_id), 32'(m_id));
            check("repeat", 32'(event_repeat), 32'(m_rep));
        end
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (ev2_count_on && ev2_valid) begin
            ev2_count++; ev2_last_id = int'(ev2_id); ev2_last_rep = int'(ev2_repeat);
        end
    endtask

    initial begin
        logic [NB-1:0] b;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(event_valid), 0);
        check("rst_id", 32'(event_id), 0);
        check("rst_overrun", 32'(overrun), 0);
        rst_in = 1'b1;
        model_reset();
        repeat (3) cycle(1, '0, 1);

        // Single held press with auto-repeat, then release.
        repeat (30) cycle(1, 4'b0010, 1);
        repeat (10) cycle(1, 4'b0000, 1);

        // Simultaneous presses and round-robin ordering.
        repeat (4) cycle(1, 4'b1101, 1);
        repeat (4) cycle(1, 4'b0000, 1);
        repeat (4) cycle(1, 4'b0101, 1);
        repeat (4) cycle(1, 4'b0000, 1);
        repeat (2) cycle(1, 4'b0001, 1);
        repeat (4) cycle(1, 4'b0000, 1);
        repeat (4) cycle(1, 4'b0101, 1);
        repeat (4) cycle(1, 4'b0000, 1);

        // Reset while an event is stuck on the port with overrun set.
        repeat (20) cycle(1, 4'b1000, 0);
        check("pre_rst_valid", 32'(event_valid), 1);
        check("pre_rst_overrun", 32'(overrun), 1);
        #2 rst_in = 1'b0;
        #1;
        check("async_rst_valid", 32'(event_valid), 0);
        check("async_rst_overrun", 32'(overrun), 0);
        enable = 1'b0; button_in = '0; event_ready = 1'b0;
        @(negedge clk);
        rst_in = 1'b1;
        model_reset();
        repeat (3) cycle(1, '0, 1);

        // Back-pressure: repeats coalesce while the first event is held.
        repeat (40) cycle(1, 4'b0001, 0);
        check("bp_overrun", 32'(overrun), 1);
        repeat (4) cycle(1, 4'b0001, 1);
        repeat (6) cycle(1, 4'b0000, 1);

        // Repeat mask: button 0 on the masked instance yields exactly one event.
        ev2_count = 0; ev2_last_id = -1; ev2_last_rep = -1;
        ev2_count_on = 1'b1;
        repeat (40) cycle(1, 4'b0001, 1);
        repeat (5) cycle(1, 4'b0000, 1);
        ev2_count_on = 1'b0;
        check("mask_count", 32'(ev2_count), 1);
        check("mask_id", 32'(ev2_last_id), 0);
        check("mask_rep", 32'(ev2_last_rep), 0);
        check("mask_overrun", 32'(ev2_overrun), 0);

        // Enable drop while button 2 repeats with a pending event.
        repeat (20) cycle(1, 4'b0100, 0);
        repeat (3) cycle(0, 4'b0100, 0);
        repeat (3) cycle(0, 4'b0100, 1);
        repeat (20) cycle(1, 4'b0100, 1);
        check("en_quiet", 32'(event_valid), 0);
        repeat (2) cycle(1, 4'b0000, 1);
        repeat (4) cycle(1, 4'b0100, 1);
        repeat (4) cycle(1, 4'b0000, 1);

        // Random traffic.
        b = '0;
        repeat (1500) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(7) == 0) b[i] = ~b[i];
            end
            cycle($urandom_range(31) != 0, b, $urandom_range(3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
